// File: rtl/rr_arb_if.sv
// Request/grant bundle between requester agents and the round-robin arbiter.
//   i_req     : per-requester request levels (W bits)
//   i_ack     : downstream accepts the current grant
//   o_gnt     : registered one-hot grant (W bits)
//   o_gnt_vld : grant valid
//   o_gnt_id  : binary index of the granted requester
// Modports: master drives requests/ack, slave is the arbiter side.
interface rr_arb_if #(
  parameter int unsigned W = 8
);
  localparam int unsigned IdW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]   i_req;
  logic           i_ack;
  logic [W-1:0]   o_gnt;
  logic           o_gnt_vld;
  logic [IdW-1:0] o_gnt_id;

  modport master (
    output i_req,
    output i_ack,
    input  o_gnt,
    input  o_gnt_vld,
    input  o_gnt_id
  );

  modport slave (
    input  i_req,
    input  i_ack,
    output o_gnt,
    output o_gnt_vld,
    output o_gnt_id
  );
endinterface

// File: rtl/rr_arb.sv
// Registered round-robin arbiter for W requesters. A rotating priority mask picks the lowest
// masked request; if none is masked-in, the lowest raw request wins. The grant is held until
// acknowledged, and a new grant can be issued on the same edge as the ack.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : rr_arb_if slave modport (i_req, i_ack in; o_gnt, o_gnt_vld, o_gnt_id out)
module rr_arb #(
  parameter int unsigned W = 8
) (
  input logic   clk,
  input logic   rst_n,
  rr_arb_if.slave bus
);
  localparam int unsigned IdW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   mask_q, mask_d;
  logic [IdW-1:0] id_q, id_d;

  logic           ack_take;
  logic [W-1:0]   sel_mask;
  logic [W-1:0]   masked;
  logic [W-1:0]   winner;

  // Fixed-priority one-hot selector, LSB first.
  function automatic logic [W-1:0] lowest(input logic [W-1:0] v);
    return v & (~v + W'(1));
  endfunction

  function automatic logic [IdW-1:0] encode(input logic [W-1:0] onehot);
    logic [IdW-1:0] id;
    id = '0;
    for (int i = 0; i < W; i++) begin
      if (onehot[i]) id = id | IdW'(i);
    end
    return id;
  endfunction

  // Bits strictly above the just-granted index; granting W-1 yields zero (wrap).
  function automatic logic [W-1:0] mask_above(input logic [IdW-1:0] id);
    logic [W-1:0] m;
    m = '0;
    for (int j = 0; j < W; j++) begin
      m[j] = (j > int'(id));
    end
    return m;
  endfunction

  always_comb begin
    ack_take = (state_q == StGrant) && bus.i_ack;
    // On an ack the next winner must already see the rotated mask.
    sel_mask = ack_take ? mask_above(id_q) : mask_q;
    masked   = bus.i_req & sel_mask;
    winner   = (|masked) ? lowest(masked) : lowest(bus.i_req);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    mask_d  = mask_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.i_req) begin
          gnt_d   = winner;
          id_d    = encode(winner);
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (bus.i_ack) begin
          mask_d = mask_above(id_q);
          if (|bus.i_req) begin
            gnt_d = winner;
            id_d  = encode(winner);
          end else begin
            gnt_d   = '0;
            id_d    = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      id_q    <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.o_gnt     = gnt_q;
  assign bus.o_gnt_vld = (state_q == StGrant);
  assign bus.o_gnt_id  = id_q;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.o_gnt));
  a_vld: assert property (@(posedge clk) disable iff (!rst_n) bus.o_gnt_vld == (|bus.o_gnt));
  a_id: assert property (@(posedge clk) disable iff (!rst_n)
    bus.o_gnt_vld ? (bus.o_gnt == (W'(1) << bus.o_gnt_id)) : (bus.o_gnt_id == '0));
  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
    bus.o_gnt_vld && !bus.i_ack |=> $stable(bus.o_gnt));
  a_hold_req: assert property (@(posedge clk) disable iff (!rst_n)
    bus.o_gnt_vld && !bus.i_ack |-> |(bus.i_req & bus.o_gnt));
endmodule

// File: tb/tb_rr_arb.sv
module tb_rr_arb;
  localparam int unsigned W   = 4;
  localparam int unsigned IdW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb_if #(.W(W)) bus ();

  rr_arb #(.W(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Expected granted index per cycle, -1 meaning no grant.
  int exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: current grant and last acknowledged index.
  int cur  = -1;
  int last = W - 1;

  // Circular search starting just after the last acknowledged requester.
  function automatic int pick(input logic [W-1:0] req, input int from);
    for (int o = 1; o <= W; o++) begin
      int idx;
      idx = (from + o) % W;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive(input logic [W-1:0] req, input logic ack, input logic rstn);
    @(negedge clk);
    bus.i_req = req;
    bus.i_ack = ack;
    rst_n     = rstn;
    if (!rstn) begin
      cur  = -1;
      last = W - 1;
    end else if (cur < 0) begin
      cur = pick(req, last);
    end else if (ack) begin
      last = cur;
      cur  = pick(req, last);
    end
  endtask

  task automatic step(input logic [W-1:0] req, input logic ack, input logic rstn);
    drive(req, ack, rstn);
    exp_q.push_back(cur);
  endtask

  // Directed step with a hand-derived expected index.
  task automatic step_exp(input logic [W-1:0] req, input logic ack, input logic rstn,
                          input int exp_idx);
    drive(req, ack, rstn);
    exp_q.push_back(exp_idx);
  endtask

  // Monitor: checks the registered outputs shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        int             e;
        logic [W-1:0]   eg;
        logic           ev;
        logic [IdW-1:0] eid;
        e   = exp_q.pop_front();
        eg  = (e < 0) ? '0 : (W'(1) << e);
        ev  = (e >= 0);
        eid = (e < 0) ? '0 : IdW'(e);
        vectors++;
        if (bus.o_gnt !== eg || bus.o_gnt_vld !== ev || bus.o_gnt_id !== eid) begin
          miscompares++;
          $display("FAIL grant vec %0d t=%0t: got gnt=%b vld=%b id=%0d, want gnt=%b vld=%b id=%0d",
                   vectors, $time, bus.o_gnt, bus.o_gnt_vld, bus.o_gnt_id, eg, ev, eid);
        end
      end
    end
  end

  initial begin
    bus.i_req = '0;
    bus.i_ack = 1'b0;
    rst_n     = 1'b0;

    // Reset, then a first request.
    step_exp(4'b0000, 1'b0, 1'b0, -1);
    step_exp(4'b0000, 1'b0, 1'b0, -1);
    step_exp(4'b1010, 1'b0, 1'b1, 1);
    step_exp(4'b0000, 1'b0, 1'b0, -1);

    // All requesting, ack every cycle: full rotation without bubbles.
    step_exp(4'b1111, 1'b1, 1'b1, 0);
    step_exp(4'b1111, 1'b1, 1'b1, 1);
    step_exp(4'b1111, 1'b1, 1'b1, 2);
    step_exp(4'b1111, 1'b1, 1'b1, 3);
    step_exp(4'b1111, 1'b1, 1'b1, 0);

    // Sticky grant while unacknowledged, then advance.
    for (int i = 0; i < 5; i++) step_exp(4'b0011, 1'b0, 1'b1, 0);
    step_exp(4'b0011, 1'b1, 1'b1, 1);

    // Wrap after granting the top index.
    step_exp(4'b1010, 1'b1, 1'b1, 3);
    step_exp(4'b0101, 1'b1, 1'b1, 0);
    step_exp(4'b0100, 1'b1, 1'b1, 2);

    // Return to idle; spurious ack while idle.
    step_exp(4'b0000, 1'b1, 1'b1, -1);
    step_exp(4'b0000, 1'b1, 1'b1, -1);
    step_exp(4'b0000, 1'b0, 1'b1, -1);

    // Reset while a grant is pending restores full priority mask.
    step_exp(4'b0010, 1'b0, 1'b1, 1);
    step_exp(4'b0110, 1'b1, 1'b1, 2);
    step_exp(4'b0110, 1'b0, 1'b0, -1);
    step_exp(4'b1111, 1'b0, 1'b1, 0);

    // Randomised traffic; the granted requester holds its request until acked.
    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] r;
      logic         a;
      logic         rs;
      r  = W'($urandom_range(0, 15));
      if (n % 3 == 0) r = r & W'($urandom);
      a  = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 63) != 0);
      if (cur >= 0 && !a) r[cur] = 1'b1;
      step(r, a, rs);
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rr_arb.md
Name: rr_arb

Overview:
- Registered round-robin arbiter for W requesters.
- Masks the request vector with a rotating priority pointer, then resolves it with a fixed-priority one-hot selector (LSB-first) on two paths: masked requests and raw requests.
- Holds the resulting grant stable until the downstream consumer acknowledges it.
- Sits between requester agents and a shared resource (bus port, queue write slot). Gives starvation-free access where a plain priority selector would starve high-index requesters.

Parameters:
- W, 8, number of requesters; legal range 1..64.
- ID_W, $clog2(W) (min 1), width of the encoded grant index; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- i_req  input  W  per-requester request level. Requester k holds i_req[k] high until it sees its grant acknowledged.
- i_ack  input  1  downstream accepts the current grant this cycle. Meaningful only while o_gnt_vld=1.
- o_gnt  output  W  registered one-hot grant; all-zero when o_gnt_vld=0.
- o_gnt_vld  output  1  grant valid.
- o_gnt_id  output  ID_W  binary index of the set bit in o_gnt; 0 when o_gnt_vld=0.

Behaviour:
- Reset (rst_n=0 sampled on a rising edge):
  - o_gnt=0, o_gnt_vld=0, o_gnt_id=0, state=IDLE.
  - Priority mask register = all-ones, so index 0 has highest priority after reset.
  - Reset overrides every other input in the same cycle, including mid-grant; any in-flight grant is dropped without a mask update.
- Mask semantics:
  - After granting index k, the mask has bits j>k set and bits j<=k clear.
  - Granting index W-1 yields mask=0, which is the wrap condition.
- Selection (combinational):
  - masked = i_req & mask.
  - If masked != 0: winner = lowest set bit of masked.
  - Otherwise: winner = lowest set bit of i_req.
  - Each path uses a fixed-priority one-hot selector, LSB-first.
  - When the state advances on an ack (see GRANT below), selection uses the post-ack mask, i.e. the mask computed from the grant being acked.
- State machine, 2 states: IDLE, GRANT.
  - IDLE, |i_req=1: register winner into o_gnt/o_gnt_id, set o_gnt_vld=1, go to GRANT. Latency is 1 cycle from request sampled to o_gnt_vld.
  - IDLE, i_req=0: stay in IDLE; outputs stay zero.
  - GRANT, i_ack=0: o_gnt, o_gnt_id and mask hold. Grant is sticky: it is not revoked even if the granted i_req bit drops (protocol violation, flagged by assertion).
  - GRANT, i_ack=1: mask <= bits above the current o_gnt_id.
    - If i_req has any bit set other than the acked index, or the acked index itself is still set: new grant registered on the same edge, stay in GRANT (back-to-back, no bubble).
    - Otherwise: clear outputs, go to IDLE.
  - i_ack while in IDLE: ignored.
- Fairness: a continuously asserted requester is granted within W consecutive grants.
- W=1:
  - Mask logic degenerates; o_gnt=i_req registered; o_gnt_id is tied to 0.
  - Back-to-back grants to index 0 occur while i_req=1.
- Assertions (simulation only):
  - o_gnt is onehot0.
  - o_gnt_vld == |o_gnt.
  - o_gnt_id matches o_gnt.
  - o_gnt stable while o_gnt_vld & !i_ack.
  - The granted requester does not drop i_req before ack.

Test Plan (W=4):
- Reset then i_req=4'b1010 -> during reset all outputs 0; first cycle after the request is sampled: o_gnt=4'b0010, o_gnt_id=1, o_gnt_vld=1.
- i_req=4'b1111 held, i_ack=1 every cycle -> o_gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, no bubbles; o_gnt_id 0,1,2,3,0.
- i_req=4'b0011, i_ack=0 for 5 cycles -> o_gnt=0001 stable for all 5; then i_ack=1 for one cycle -> next cycle o_gnt=0010.
- Wrap: grant 1000 acked (mask=0) with i_req=4'b0101 -> next o_gnt=0001. Then ack with i_req=4'b0100 -> o_gnt=0100.
- Single requester: i_req=4'b0100, acked, then i_req=0 -> o_gnt_vld drops to 0 the next cycle and state returns to IDLE. A spurious i_ack=1 while idle causes no change.
- Reset mid-operation: sequence to mask=4'b1100, assert rst_n=0 while o_gnt=0100 is pending -> outputs 0 next cycle. After release, i_req=4'b1111 grants 0001 first, proving the mask was restored to all-ones.
